// File: rtl/rv32i_pkg.sv
// rv32i_pkg: shared constants and types for the RV32I decode/issue stage.
//   XLEN/NREG/AW   datapath width, register count, register index width
//   OP_*           major opcodes recognised by the decoder
//   CLS_*          4-bit opcode class driven on ex_class (0 = no class / illegal)
//   imm_t          immediate format selector; imm_gen builds the sign-extended value
//   slot_t         decoded fields held in the issue slot
package rv32i_pkg;

   localparam int XLEN = 32;
   localparam int NREG = 32;
   localparam int AW   = $clog2(NREG);

   localparam logic [6:0] OP_LUI    = 7'b0110111;
   localparam logic [6:0] OP_AUIPC  = 7'b0010111;
   localparam logic [6:0] OP_JAL    = 7'b1101111;
   localparam logic [6:0] OP_JALR   = 7'b1100111;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_OPIMM  = 7'b0010011;
   localparam logic [6:0] OP_OP     = 7'b0110011;
   localparam logic [6:0] OP_SYSTEM = 7'b1110011;

   localparam logic [3:0] CLS_NONE   = 4'd0;
   localparam logic [3:0] CLS_LUI    = 4'd1;
   localparam logic [3:0] CLS_AUIPC  = 4'd2;
   localparam logic [3:0] CLS_JAL    = 4'd3;
   localparam logic [3:0] CLS_JALR   = 4'd4;
   localparam logic [3:0] CLS_BRANCH = 4'd5;
   localparam logic [3:0] CLS_LOAD   = 4'd6;
   localparam logic [3:0] CLS_STORE  = 4'd7;
   localparam logic [3:0] CLS_OPIMM  = 4'd8;
   localparam logic [3:0] CLS_OP     = 4'd9;
   localparam logic [3:0] CLS_SYSTEM = 4'd10;

   typedef enum logic [2:0] {IMM_NONE, IMM_I, IMM_S, IMM_B, IMM_U, IMM_J} imm_t;

   typedef struct packed {
      logic [XLEN-1:0] pc;
      logic [3:0]      cls;
      logic [2:0]      funct3;
      logic            f7b5;
      logic [XLEN-1:0] imm;
      logic [AW-1:0]   rd;
      logic [AW-1:0]   rs1;
      logic [AW-1:0]   rs2;
      logic            rs1_zero;
      logic            rs2_zero;
      logic            illegal;
   } slot_t;

   function automatic logic [XLEN-1:0] imm_gen(input logic [XLEN-1:0] i, input imm_t t);
      case (t)
         IMM_I:   return {{20{i[31]}}, i[31:20]};
         IMM_S:   return {{20{i[31]}}, i[31:25], i[11:7]};
         IMM_B:   return {{19{i[31]}}, i[31], i[7], i[30:25], i[11:8], 1'b0};
         IMM_U:   return {i[31:12], 12'b0};
         IMM_J:   return {{11{i[31]}}, i[31], i[19:12], i[20], i[30:21], 1'b0};
         default: return '0;
      endcase
   endfunction

endpackage

// File: rtl/rv32i_decode.sv
// rv32i_decode: purely combinational RV32I field decoder.
//   instr      in   instruction word
//   cls        out  opcode class (CLS_NONE when illegal)
//   rs1/rs2    out  raw source fields
//   rd         out  destination, forced 0 when the class writes no rd
//   uses_rs1/uses_rs2/writes_rd  out  operand usage for the scoreboard
//   imm        out  sign-extended immediate for the class format
//   illegal    out  opcode not recognised
module rv32i_decode
   import rv32i_pkg::*;
(
   input  logic [XLEN-1:0] instr,
   output logic [3:0]      cls,
   output logic [AW-1:0]   rs1,
   output logic [AW-1:0]   rs2,
   output logic [AW-1:0]   rd,
   output logic            uses_rs1,
   output logic            uses_rs2,
   output logic            writes_rd,
   output logic [XLEN-1:0] imm,
   output logic            illegal
);

   imm_t       ityp;
   logic [2:0] f3;

   assign f3 = instr[14:12];

   always_comb begin
      cls       = CLS_NONE;
      uses_rs1  = 1'b0;
      uses_rs2  = 1'b0;
      writes_rd = 1'b0;
      illegal   = 1'b0;
      ityp      = IMM_NONE;
      case (instr[6:0])
         OP_LUI:    begin cls = CLS_LUI;    writes_rd = 1'b1; ityp = IMM_U; end
         OP_AUIPC:  begin cls = CLS_AUIPC;  writes_rd = 1'b1; ityp = IMM_U; end
         OP_JAL:    begin cls = CLS_JAL;    writes_rd = 1'b1; ityp = IMM_J; end
         OP_JALR:   begin cls = CLS_JALR;   writes_rd = 1'b1; uses_rs1 = 1'b1; ityp = IMM_I; end
         OP_BRANCH: begin cls = CLS_BRANCH; uses_rs1 = 1'b1; uses_rs2 = 1'b1; ityp = IMM_B; end
         OP_LOAD:   begin cls = CLS_LOAD;   writes_rd = 1'b1; uses_rs1 = 1'b1; ityp = IMM_I; end
         OP_STORE:  begin cls = CLS_STORE;  uses_rs1 = 1'b1; uses_rs2 = 1'b1; ityp = IMM_S; end
         OP_OPIMM:  begin cls = CLS_OPIMM;  writes_rd = 1'b1; uses_rs1 = 1'b1; ityp = IMM_I; end
         OP_OP:     begin cls = CLS_OP;     writes_rd = 1'b1; uses_rs1 = 1'b1; uses_rs2 = 1'b1; end
         OP_SYSTEM: begin
            // ECALL/EBREAK (funct3=0) touch no GPR; CSR*I variants carry a zimm, not rs1
            cls       = CLS_SYSTEM;
            ityp      = IMM_I;
            writes_rd = (f3 != 3'd0);
            uses_rs1  = (f3 != 3'd0) && !f3[2];
         end
         default:   illegal = 1'b1;
      endcase
   end

   assign rs1 = instr[19:15];
   assign rs2 = instr[24:20];
   assign rd  = writes_rd ? instr[11:7] : '0;
   assign imm = imm_gen(instr, ityp);

endmodule

// File: rtl/decode_issue.sv
// decode_issue: RV32I decode/issue stage feeding a registered-read 32x32 register file.
//   clk/res                 clock, async active-high reset
//   if_valid/if_ready/if_instr/if_pc   fetch handshake
//   rf_a1/rf_a2             register-file read addresses
//   ex_valid/ex_ready/ex_*  one-entry issue slot toward execute
//   wb_valid/wb_rd          writeback retire, clears scoreboard bit
//   flush                   kill slot, block acceptance this cycle
module decode_issue
   import rv32i_pkg::*;
(
   input  logic            clk,
   input  logic            res,
   input  logic            if_valid,
   output logic            if_ready,
   input  logic [XLEN-1:0] if_instr,
   input  logic [XLEN-1:0] if_pc,
   output logic [AW-1:0]   rf_a1,
   output logic [AW-1:0]   rf_a2,
   output logic            ex_valid,
   input  logic            ex_ready,
   output logic [XLEN-1:0] ex_pc,
   output logic [3:0]      ex_class,
   output logic [2:0]      ex_funct3,
   output logic            ex_funct7b5,
   output logic [XLEN-1:0] ex_imm,
   output logic [AW-1:0]   ex_rd,
   output logic            ex_rs1_zero,
   output logic            ex_rs2_zero,
   output logic            ex_illegal,
   input  logic            wb_valid,
   input  logic [AW-1:0]   wb_rd,
   input  logic            flush
);

   logic [3:0]      d_cls;
   logic [AW-1:0]   d_rs1, d_rs2, d_rd;
   logic            d_use1, d_use2, d_wr, d_ill;
   logic [XLEN-1:0] d_imm;

   rv32i_decode u_dec (
      .instr     (if_instr),
      .cls       (d_cls),
      .rs1       (d_rs1),
      .rs2       (d_rs2),
      .rd        (d_rd),
      .uses_rs1  (d_use1),
      .uses_rs2  (d_use2),
      .writes_rd (d_wr),
      .imm       (d_imm),
      .illegal   (d_ill)
   );

   slot_t           slot, d_slot;
   logic            slot_valid;
   logic [NREG-1:0] busy, busy_n;
   logic            hazard, accept;

   // d_rd is already 0 for non-writers, so the rd term needs no writes_rd gate
   assign hazard = (d_use1 && d_rs1 != '0 && busy[d_rs1])
                 | (d_use2 && d_rs2 != '0 && busy[d_rs2])
                 | (d_wr   && d_rd  != '0 && busy[d_rd]);

   // held low during reset so the rf address mux parks on the cleared slot
   assign if_ready = (!slot_valid || ex_ready) && !hazard && !flush && !res;
   assign accept   = if_valid && if_ready;

   // a stalled slot keeps its own addresses so RD1/RD2 stay aligned with it
   assign rf_a1 = accept ? d_rs1 : slot.rs1;
   assign rf_a2 = accept ? d_rs2 : slot.rs2;

   always_comb begin
      d_slot          = '0;
      d_slot.pc       = if_pc;
      d_slot.cls      = d_cls;
      d_slot.funct3   = if_instr[14:12];
      d_slot.f7b5     = if_instr[30];
      d_slot.imm      = d_imm;
      d_slot.rd       = d_rd;
      d_slot.rs1      = d_rs1;
      d_slot.rs2      = d_rs2;
      d_slot.rs1_zero = (d_rs1 == '0);
      d_slot.rs2_zero = (d_rs2 == '0);
      d_slot.illegal  = d_ill;
   end

   // set beats clear on the same index; acceptance never coincides with flush
   always_comb begin
      busy_n = busy;
      if (wb_valid) busy_n[wb_rd] = 1'b0;
      if (flush && slot_valid && slot.rd != '0) busy_n[slot.rd] = 1'b0;
      if (accept && d_wr && d_rd != '0) busy_n[d_rd] = 1'b1;
      busy_n[0] = 1'b0;
   end

   always_ff @(posedge clk or posedge res) begin
      if (res) begin
         slot_valid <= 1'b0;
         slot       <= '0;
         busy       <= '0;
      end else begin
         busy <= busy_n;
         if (accept) begin
            slot_valid <= 1'b1;
            slot       <= d_slot;
         end else if (flush || ex_ready) begin
            slot_valid <= 1'b0;
         end
      end
   end

   assign ex_valid    = slot_valid;
   assign ex_pc       = slot.pc;
   assign ex_class    = slot.cls;
   assign ex_funct3   = slot.funct3;
   assign ex_funct7b5 = slot.f7b5;
   assign ex_imm      = slot.imm;
   assign ex_rd       = slot.rd;
   assign ex_rs1_zero = slot.rs1_zero;
   assign ex_rs2_zero = slot.rs2_zero;
   assign ex_illegal  = slot.illegal;

endmodule
